// File: rtl/time_counter_pkg.sv
// Shared constants and BCD step helper for the
// time-of-day counter.
package time_counter_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam int CLK_DIV_DEF = 50_000_000;

  // Max is tested before the digit rule so 23 wraps
  // while 19 still carries into 20.
  function automatic logic [7:0] bcd_next(
    input logic [7:0] v,
    input logic [7:0] max
  );
    logic [7:0] n;
    if (v >= max)
      n = 8'h00;
    else if (v[3:0] >= 4'd9)
      n = {v[7:4] + 4'd1, 4'd0};
    else
      n = {v[7:4], v[3:0] + 4'd1};
    return n;
  endfunction

endpackage

// File: rtl/time_counter_bcd_wrap_counter.sv
// Two-digit BCD counter with wrap at MAX and a
// registered one-cycle wrap pulse.
module bcd_wrap_counter
  import time_counter_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] r_value;
  logic       r_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= 8'h00;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_value <= 8'h00;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (inc) begin
        r_value <= bcd_next(r_value, MAX);
        r_wrap  <= (r_value == MAX);
      end
    end
  end

  assign value = r_value;
  assign wrap  = r_wrap;

endmodule

// File: rtl/time_counter.sv
// Clock fields with tick edge detect, independent
// BCD counters and a 1 Hz prescaler.
module time_counter
  import time_counter_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter bit EDGE_RST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       tick_s,
  input  logic       tick_m,
  input  logic       tick_h,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       sbit,
  output logic       mbit,
  output logic       pulse_1hz
);

  localparam int CW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLK_DIV - 1);

  // bit order {h, m, s}
  logic [2:0]    r_tick_q;
  logic [2:0]    r_tick_p;
  logic [2:0]    w_inc;
  logic [CW-1:0] r_cnt;
  logic          w_hour_wrap_unused;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_q <= {3{EDGE_RST}};
      r_tick_p <= {3{EDGE_RST}};
    end else begin
      r_tick_q <= {tick_h, tick_m, tick_s};
      r_tick_p <= r_tick_q;
    end
  end

  assign w_inc = r_tick_q & ~r_tick_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (r_cnt == CNT_LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CW'(1);
  end

  assign pulse_1hz = (r_cnt == CNT_LAST);

  bcd_wrap_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_inc[0]),
    .value (second),
    .wrap  (sbit)
  );

  bcd_wrap_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_inc[1]),
    .value (minute),
    .wrap  (mbit)
  );

  // Hour rollover is silent at the top level.
  bcd_wrap_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_inc[2]),
    .value (hour),
    .wrap  (w_hour_wrap_unused)
  );

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: vector table
// plus hand sequences for wraps, clr and reset.
module tb_time_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       tick_s;
  logic       tick_m;
  logic       tick_h;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       sbit;
  logic       mbit;
  logic       pulse_1hz;

  int checks   = 0;
  int failures = 0;

  time_counter #(
    .CLK_DIV  (4),
    .EDGE_RST (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .tick_s    (tick_s),
    .tick_m    (tick_m),
    .tick_h    (tick_h),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .sbit      (sbit),
    .mbit      (mbit),
    .pulse_1hz (pulse_1hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ts;
    logic        tm;
    logic        th;
    logic        cl;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [25:0] st();
    return {hour, minute, second, sbit, mbit};
  endfunction

  function automatic logic [25:0] mk(
    input logic [7:0] h,
    input logic [7:0] m,
    input logic [7:0] s,
    input logic       sb,
    input logic       mb
  );
    return {h, m, s, sb, mb};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [25:0] act,
    input logic [25:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h",
               nm, act, exp);
    end
  endtask

  task automatic chk1(
    input string nm,
    input logic  act,
    input logic  exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b",
               nm, act, exp);
    end
  endtask

  // Called at a negedge; ends at the next negedge.
  task automatic step(
    input logic ts,
    input logic tm,
    input logic th,
    input logic cl
  );
    tick_s = ts;
    tick_m = tm;
    tick_h = th;
    clr    = cl;
    @(posedge clk);
    @(negedge clk);
  endtask

  // mask is {h, m, s}; each rise takes two cycles.
  task automatic tick_n(
    input logic [2:0] mask,
    input int         n
  );
    for (int i = 0; i < n; i++) begin
      step(mask[0], mask[1], mask[2], 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    tbl[0] = '{0,0,0,0, mk(8'h00,8'h00,8'h00,0,0)};
    tbl[1] = '{1,0,0,0, mk(8'h00,8'h00,8'h00,0,0)};
    tbl[2] = '{1,0,0,0, mk(8'h00,8'h00,8'h01,0,0)};
    tbl[3] = '{1,0,0,0, mk(8'h00,8'h00,8'h01,0,0)};
    tbl[4] = '{0,0,0,0, mk(8'h00,8'h00,8'h01,0,0)};
    tbl[5] = '{0,1,0,0, mk(8'h00,8'h00,8'h01,0,0)};
    tbl[6] = '{0,1,0,0, mk(8'h00,8'h01,8'h01,0,0)};
    tbl[7] = '{0,0,0,0, mk(8'h00,8'h01,8'h01,0,0)};
    tbl[8] = '{1,0,1,0, mk(8'h00,8'h01,8'h01,0,0)};
    tbl[9] = '{0,0,0,0, mk(8'h01,8'h01,8'h02,0,0)};

    reset  = 1'b0;
    clr    = 1'b0;
    tick_s = 1'b1;
    tick_m = 1'b0;
    tick_h = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_fields", st(), '0);
    chk1("rst_pulse", pulse_1hz, 1'b0);

    // Release with tick_s already high.
    reset = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk1($sformatf("pulse_c%0d", n),
           pulse_1hz, (n % 4) == 3);
    end
    chk("held_at_rel", st(), '0);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].ts, tbl[i].tm,
           tbl[i].th, tbl[i].cl);
      chk($sformatf("vec%0d", i), st(), tbl[i].exp);
    end

    // Seconds wrap.
    tick_n(3'b001, 56);
    chk("s58", st(), mk(8'h01,8'h01,8'h58,0,0));
    tick_n(3'b001, 1);
    chk("s59", st(), mk(8'h01,8'h01,8'h59,0,0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("s59_pend", st(), mk(8'h01,8'h01,8'h59,0,0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s_wrap", st(), mk(8'h01,8'h01,8'h00,1,0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s_wrap_end", st(), mk(8'h01,8'h01,8'h00,0,0));

    // Hour digit carries and 23 -> 00.
    tick_n(3'b100, 8);
    chk("h09", st(), mk(8'h09,8'h01,8'h00,0,0));
    tick_n(3'b100, 1);
    chk("h10", st(), mk(8'h10,8'h01,8'h00,0,0));
    tick_n(3'b100, 9);
    chk("h19", st(), mk(8'h19,8'h01,8'h00,0,0));
    tick_n(3'b100, 1);
    chk("h20", st(), mk(8'h20,8'h01,8'h00,0,0));
    tick_n(3'b100, 3);
    chk("h23", st(), mk(8'h23,8'h01,8'h00,0,0));
    tick_n(3'b100, 1);
    chk("h_wrap", st(), mk(8'h00,8'h01,8'h00,0,0));

    // Simultaneous wrap at 59:59.
    tick_n(3'b010, 58);
    tick_n(3'b001, 59);
    chk("ms5959", st(), mk(8'h00,8'h59,8'h59,0,0));
    tick_n(3'b011, 1);
    chk("ms_wrap", st(), mk(8'h00,8'h00,8'h00,1,1));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ms_wrap_end", st(), '0);

    // clr against a pending minute increment.
    tick_n(3'b010, 12);
    tick_n(3'b001, 3);
    chk("m12", st(), mk(8'h00,8'h12,8'h03,0,0));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("m12_pend", st(), mk(8'h00,8'h12,8'h03,0,0));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_win", st(), '0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_after", st(), '0);

    // Async reset while pulse_1hz is high.
    tick_n(3'b001, 3);
    for (int i = 0; i < 8 && !pulse_1hz; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("pulse_found", pulse_1hz, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk1("pre_rst_pulse", pulse_1hz, 1'b1);
    chk("pre_rst", st(), mk(8'h00,8'h00,8'h03,0,0));
    #2;
    reset  = 1'b0;
    tick_s = 1'b0;
    #1;
    chk("async_fields", st(), '0);
    chk1("async_pulse", pulse_1hz, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk1($sformatf("re_pulse_c%0d", n),
           pulse_1hz, n == 3);
    end
    chk("aborted", st(), '0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
